// File: rtl/dynamic_fault_checker_mw_pkg.sv
// Shared types for the multi-lane dynamic fault checker: decoded instruction
// layout, privilege/FPU-status encodings and the per-lane fault cause codes.
package dynamic_fault_checker_mw_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_lvl_t;

    typedef enum logic [1:0] {
        XS_OFF     = 2'b00,
        XS_INITIAL = 2'b01,
        XS_CLEAN   = 2'b10,
        XS_DIRTY   = 2'b11
    } xs_t;

    typedef enum logic [2:0] {
        FU_NONE   = 3'd0,
        FU_ALU    = 3'd1,
        FU_LSU    = 3'd2,
        FU_CSR    = 3'd3,
        FU_FPU    = 3'd4,
        FU_BRANCH = 3'd5
    } fu_t;

    typedef enum logic [3:0] {
        OP_ADD        = 4'd0,
        OP_LOAD       = 4'd1,
        OP_SRET       = 4'd2,
        OP_MRET       = 4'd3,
        OP_DRET       = 4'd4,
        OP_WFI        = 4'd5,
        OP_SFENCE_VMA = 4'd6,
        OP_FADD       = 4'd7,
        OP_FMUL       = 4'd8,
        OP_CSRRW      = 4'd9
    } op_t;

    typedef struct packed {
        fu_t        fu;
        op_t        op;
        logic [2:0] rm;
        logic [4:0] rd;
        logic [4:0] rs1;
    } si_t;

    typedef logic [3:0] cause_t;

    localparam cause_t CAUSE_NONE   = 4'd0;
    localparam cause_t CAUSE_SRET   = 4'd1;
    localparam cause_t CAUSE_MRET   = 4'd2;
    localparam cause_t CAUSE_DRET   = 4'd3;
    localparam cause_t CAUSE_WFI    = 4'd4;
    localparam cause_t CAUSE_VMA    = 4'd5;
    localparam cause_t CAUSE_FS_OFF = 4'd6;
    localparam cause_t CAUSE_FRM    = 4'd7;

    // Reserved static modes 5/6, or dynamic mode pointing at a reserved frm.
    function automatic logic rm_illegal(input logic [2:0] rm, input logic [2:0] frm);
        return (rm == 3'd5) || (rm == 3'd6) || ((rm == 3'd7) && (frm >= 3'd5));
    endfunction

endpackage

// File: rtl/dynamic_fault_checker_mw_if.sv
// Decode-bundle bus into and out of the fault checker stage.
interface dynamic_fault_checker_mw_if #(
    parameter int NLANES  = 2,
    parameter int CAUSE_W = 4
);
    import dynamic_fault_checker_mw_pkg::*;

    localparam int FF_W = $clog2(NLANES) + 1;

    logic                             in_valid_i;
    logic                             in_ready_o;
    logic [NLANES-1:0]                lane_valid_i;
    si_t  [NLANES-1:0]                si_i;
    logic                             out_valid_o;
    logic                             out_ready_i;
    si_t  [NLANES-1:0]                si_o;
    logic [NLANES-1:0]                lane_valid_o;
    logic [NLANES-1:0]                fault_o;
    logic [NLANES-1:0][CAUSE_W-1:0]   cause_o;
    logic [FF_W-1:0]                  first_fault_o;

    modport master (
        output in_valid_i, lane_valid_i, si_i, out_ready_i,
        input  in_ready_o, out_valid_o, si_o, lane_valid_o, fault_o, cause_o, first_fault_o
    );

    modport slave (
        input  in_valid_i, lane_valid_i, si_i, out_ready_i,
        output in_ready_o, out_valid_o, si_o, lane_valid_o, fault_o, cause_o, first_fault_o
    );

endinterface

// File: rtl/dynamic_fault_checker_mw_fault_lane_check.sv
// Combinational check of one decoded instruction against the CSR snapshot,
// producing the highest-priority fault cause for that lane.
module dynamic_fault_checker_mw_fault_lane_check
    import dynamic_fault_checker_mw_pkg::*;
(
    input  logic       valid_i,
    input  si_t        si_i,
    input  xs_t        fs_i,
    input  priv_lvl_t  priv_lvl_i,
    input  logic [2:0] frm_i,
    input  logic       tvm_i,
    input  logic       tw_i,
    input  logic       tsr_i,
    input  logic       debug_mode_i,
    output cause_t     cause_o
);

    logic priv_u_s;
    logic priv_s_s;
    logic fpu_s;
    logic unused_s;

    assign priv_u_s = (priv_lvl_i == PRIV_U);
    assign priv_s_s = (priv_lvl_i == PRIV_S);
    assign fpu_s    = (si_i.fu == FU_FPU);
    assign unused_s = ^{si_i.rd, si_i.rs1};

    // First matching rule wins; invalid lanes never fault.
    always_comb begin
        cause_o = CAUSE_NONE;
        if (!valid_i) begin
            cause_o = CAUSE_NONE;
        end else if ((si_i.op == OP_SRET) && (priv_u_s || (priv_s_s && tsr_i))) begin
            cause_o = CAUSE_SRET;
        end else if ((si_i.op == OP_MRET) && (priv_lvl_i != PRIV_M)) begin
            cause_o = CAUSE_MRET;
        end else if ((si_i.op == OP_DRET) && !debug_mode_i) begin
            cause_o = CAUSE_DRET;
        end else if ((si_i.op == OP_WFI) && (priv_u_s || (priv_s_s && tw_i))) begin
            cause_o = CAUSE_WFI;
        end else if ((si_i.op == OP_SFENCE_VMA) && (priv_u_s || (priv_s_s && tvm_i))) begin
            cause_o = CAUSE_VMA;
        end else if (fpu_s && (fs_i == XS_OFF)) begin
            cause_o = CAUSE_FS_OFF;
        end else if (fpu_s && rm_illegal(si_i.rm, frm_i)) begin
            cause_o = CAUSE_FRM;
        end else begin
            cause_o = CAUSE_NONE;
        end
    end

endmodule

// File: rtl/dynamic_fault_checker_mw.sv
// Multi-lane dynamic fault checker: per-lane cause, kill of lanes younger than
// the oldest fault, one elastic output register and a saturating fault counter.
module dynamic_fault_checker_mw
    import dynamic_fault_checker_mw_pkg::*;
#(
    parameter int NLANES  = 2,
    parameter int CAUSE_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  xs_t              fs_i,
    input  priv_lvl_t        priv_lvl_i,
    input  logic [2:0]       frm_i,
    input  logic             tvm_i,
    input  logic             tw_i,
    input  logic             tsr_i,
    input  logic             debug_mode_i,
    output logic [CNT_W-1:0] fault_cnt_o,
    dynamic_fault_checker_mw_if.slave bus
);

    localparam int              FF_W    = $clog2(NLANES) + 1;
    localparam logic [FF_W-1:0] NONE    = FF_W'(NLANES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    cause_t                         cause_s [NLANES];
    logic [FF_W-1:0]                first_s;
    logic                           accept_s;

    logic                           out_valid_q, out_valid_d;
    si_t  [NLANES-1:0]              si_q, si_d;
    logic [NLANES-1:0]              lane_valid_q, lane_valid_d;
    logic [NLANES-1:0]              fault_q, fault_d;
    logic [NLANES-1:0][CAUSE_W-1:0] cause_q, cause_d;
    logic [FF_W-1:0]                first_q, first_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;

    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        dynamic_fault_checker_mw_fault_lane_check u_check (
            .valid_i      (bus.lane_valid_i[g]),
            .si_i         (bus.si_i[g]),
            .fs_i         (fs_i),
            .priv_lvl_i   (priv_lvl_i),
            .frm_i        (frm_i),
            .tvm_i        (tvm_i),
            .tw_i         (tw_i),
            .tsr_i        (tsr_i),
            .debug_mode_i (debug_mode_i),
            .cause_o      (cause_s[g])
        );
    end

    assign bus.in_ready_o = !out_valid_q || bus.out_ready_i;
    assign accept_s       = bus.in_valid_i && bus.in_ready_o && !flush_i;

    // Oldest faulting lane: scanning young to old leaves the lowest index.
    always_comb begin
        first_s = NONE;
        for (int i = NLANES - 1; i >= 0; i--) begin
            first_s = (cause_s[i] != CAUSE_NONE) ? FF_W'(i) : first_s;
        end
    end

    // Next state of the output stage and the fault counter.
    always_comb begin
        out_valid_d  = out_valid_q;
        si_d         = si_q;
        lane_valid_d = lane_valid_q;
        fault_d      = fault_q;
        cause_d      = cause_q;
        first_d      = first_q;
        cnt_d        = cnt_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            si_d        = bus.si_i;
            first_d     = first_s;
            // Only the oldest faulting lane can carry a cause; younger lanes die.
            for (int i = 0; i < NLANES; i++) begin
                lane_valid_d[i] = bus.lane_valid_i[i] && (FF_W'(i) <= first_s);
                fault_d[i]      = (FF_W'(i) == first_s);
                cause_d[i]      = (FF_W'(i) == first_s) ? CAUSE_W'(cause_s[i]) : {CAUSE_W{1'b0}};
            end
            if ((first_s != NONE) && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else if (bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            si_q         <= '0;
            lane_valid_q <= {NLANES{1'b0}};
            fault_q      <= {NLANES{1'b0}};
            cause_q      <= '0;
            first_q      <= NONE;
            cnt_q        <= {CNT_W{1'b0}};
        end else begin
            out_valid_q  <= out_valid_d;
            si_q         <= si_d;
            lane_valid_q <= lane_valid_d;
            fault_q      <= fault_d;
            cause_q      <= cause_d;
            first_q      <= first_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.out_valid_o   = out_valid_q;
    assign bus.si_o          = si_q;
    assign bus.lane_valid_o  = lane_valid_q;
    assign bus.fault_o       = fault_q;
    assign bus.cause_o       = cause_q;
    assign bus.first_fault_o = first_q;
    assign fault_cnt_o       = cnt_q;

endmodule

// File: doc/dynamic_fault_checker_mw.md
Name: dynamic_fault_checker_mw

Overview:
- Multi-lane, registered successor to the single-instruction dynamic fault check.
- Sits between decode and rename/dispatch. Checks each lane of a decode bundle against a per-cycle CSR snapshot and encodes a per-lane fault cause, including the FPU rounding-mode check.
- Kills every lane younger than the first faulting lane and holds the bundle in one elastic output stage with valid/ready.
- Keeps a saturating count of faults.

Parameters:
- NLANES, 2, decode lanes per bundle (1..8).
- CAUSE_W, 4, width of the per-lane cause code.
- CNT_W, 16, width of the saturating fault counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  pipeline flush
- in_valid_i  in  1  bundle valid
- in_ready_o  out  1  stage can accept
- lane_valid_i  in  NLANES  per-lane valid
- si_i  in  NLANES x C::si_t  decoded instructions, lane 0 oldest
- fs_i  in  RV::xs_t  FPU status
- priv_lvl_i  in  RV::priv_lvl_t  current privilege
- frm_i  in  3  dynamic rounding mode
- tvm_i, tw_i, tsr_i, debug_mode_i  in  1 each  CSR trap flags
- out_valid_o  out  1  bundle valid
- out_ready_i  in  1  downstream accepts
- si_o  out  NLANES x C::si_t  registered instructions
- lane_valid_o  out  NLANES  surviving lanes; the faulting lane stays valid
- fault_o  out  NLANES  lane faults
- cause_o  out  NLANES x CAUSE_W  cause per lane
- first_fault_o  out  $clog2(NLANES)+1  index of oldest fault; NLANES if none
- fault_cnt_o  out  CNT_W  saturating count of accepted faulting bundles

Behaviour:
- Reset (clk edge with rst=1):
  - out_valid_o=0, lane_valid_o=0, fault_o=0, cause_o=0, first_fault_o=NLANES, fault_cnt_o=0.
  - si_o is don't-care.
  - in_ready_o=1 in the cycle after reset.
- Handshake:
  - in_ready_o = !out_valid_o || out_ready_i (combinational).
  - Accept when in_valid_i && in_ready_o.
  - Latency is 1 cycle, input to output.
  - The output holds stable while out_valid_o && !out_ready_i.
  - Full throughput when out_ready_i=1.
- Per-lane check, combinational. Only lanes with lane_valid_i=1 are checked. Priority is the first match below, codes in the package:
  - SRET with U, or S with tsr -> CAUSE_SRET(1).
  - MRET with priv != M -> CAUSE_MRET(2).
  - DRET with !debug_mode -> CAUSE_DRET(3).
  - WFI with U, or S with tw -> CAUSE_WFI(4).
  - FENCE_VMA with U, or S with tvm -> CAUSE_VMA(5).
  - fu==FU_FPU with fs_i==XS_OFF -> CAUSE_FS_OFF(6).
  - fu==FU_FPU with si.rm in {5,6}, or si.rm==7 with frm_i in {5,6,7} -> CAUSE_FRM(7).
  - Otherwise cause=0 (CAUSE_NONE).
- Kill rule:
  - first = lowest lane index with a fault, NLANES if none.
  - Registered lane_valid for lane i = lane_valid_i[i] && (i <= first).
  - fault and cause of killed lanes register as 0.
- CSR inputs are sampled on the accept cycle only.
- Counter:
  - Increments by 1 on each accept with first<NLANES.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared by rst only.
- Flush:
  - flush_i=1 forces out_valid_o=0 next cycle and blocks acceptance that cycle, even if in_valid_i && in_ready_o.
  - The counter does not increment for that cycle.
  - Flush has priority over out_ready_i.
- Edge cases:
  - An empty bundle (lane_valid_i=0) is still accepted and passed with lane_valid_o=0 and no fault.
  - rst during a stall drops the held bundle.

Decomposition:
- C package: add cause_t and CAUSE_* constants, and the si_t.rm field if it is absent.
- Sub-module fault_lane_check: purely combinational, one si_t plus CSR flags to cause_t, instantiated NLANES times.
- Top level holds first-fault priority, kill mask, output register and counter.

Test Plan:
- NLANES=2, U-mode, lane0=ADD, lane1=MRET, out_ready=1 -> next cycle out_valid=1, lane_valid_o=11, fault_o=10, cause_o[1]=2, first_fault_o=1, fault_cnt_o=1.
- S-mode tsr=1, lane0=SRET, lane1=ADD -> lane_valid_o=01, cause_o[0]=1, first_fault_o=0; lane1 killed.
- FPU op with rm=7, frm_i=5, fs=XS_DIRTY -> cause 7; same op with fs=XS_OFF -> cause 6 (priority).
- Back-pressure: out_ready=0 for 3 cycles with a new bundle presented -> in_ready_o=0, outputs held unchanged; release -> both bundles delivered in order, no duplicate counting.
- flush_i asserted together with a valid accept -> next cycle out_valid_o=0, fault_cnt_o unchanged.
- CNT_W=2, 5 faulting bundles -> fault_cnt_o reads 1,2,3,3,3; rst -> fault_cnt_o=0, out_valid_o=0.
